// File: rtl/ascii_to_ps2_tx_pkg.sv
// Shared constants for the ASCII-to-PS/2 transmitter: scan codes, frame geometry, FSM encoding.
package ascii_to_ps2_tx_pkg;

    localparam logic [7:0] BREAK_CODE = 8'hF0;

    localparam logic [7:0] SC_0 = 8'h45;
    localparam logic [7:0] SC_1 = 8'h16;
    localparam logic [7:0] SC_2 = 8'h1E;
    localparam logic [7:0] SC_3 = 8'h26;
    localparam logic [7:0] SC_4 = 8'h25;
    localparam logic [7:0] SC_5 = 8'h2E;
    localparam logic [7:0] SC_6 = 8'h36;
    localparam logic [7:0] SC_7 = 8'h3D;
    localparam logic [7:0] SC_8 = 8'h3E;
    localparam logic [7:0] SC_9 = 8'h46;
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_B = 8'h32;
    localparam logic [7:0] SC_C = 8'h21;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_E = 8'h24;
    localparam logic [7:0] SC_F = 8'h2B;

    localparam logic [3:0] LAST_BIT   = 4'd10;
    localparam logic [1:0] LAST_FRAME = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_e;

    // Line level for bit idx of an 11-bit frame: start, 8 data LSB first, odd parity, stop.
    function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
        logic b;
        b = 1'b1;
        if (idx == 4'd0)
            b = 1'b0;
        else if (idx <= 4'd8)
            b = data[3'(idx - 4'd1)];
        else if (idx == 4'd9)
            b = ~^data;
        return b;
    endfunction

endpackage

// File: rtl/ascii_to_ps2_tx_scan.sv
// Combinational ASCII to PS/2 set-2 make-code lookup for '0'-'9' and 'A'-'F'.
module ascii_to_scan
    import ascii_to_ps2_tx_pkg::*;
(
    input  logic [7:0] ascii,
    output logic [7:0] scan,
    output logic       hit
);

    always_comb begin
        scan = 8'h00;
        hit  = 1'b1;
        case (ascii)
            8'h30: scan = SC_0;
            8'h31: scan = SC_1;
            8'h32: scan = SC_2;
            8'h33: scan = SC_3;
            8'h34: scan = SC_4;
            8'h35: scan = SC_5;
            8'h36: scan = SC_6;
            8'h37: scan = SC_7;
            8'h38: scan = SC_8;
            8'h39: scan = SC_9;
            8'h41: scan = SC_A;
            8'h42: scan = SC_B;
            8'h43: scan = SC_C;
            8'h44: scan = SC_D;
            8'h45: scan = SC_E;
            8'h46: scan = SC_F;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/ascii_to_ps2_tx.sv
// Sends a character as PS/2 make / F0 / make frames with device-driven clock and idle gaps.
module ascii_to_ps2_tx
    import ascii_to_ps2_tx_pkg::*;
#(
    parameter int CLK_DIV  = 2500,
    parameter int GAP_BITS = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] ascii_in,
    input  logic       ascii_valid,
    output logic       ready,
    output logic       error,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int HC_W = $clog2(CLK_DIV);
    localparam int GC_W = $clog2(GAP_BITS + 1);

    tx_state_e       state_q, state_d;
    logic [HC_W-1:0] half_q, half_d;
    logic            low_q, low_d;
    logic [3:0]      bit_q, bit_d;
    logic [GC_W-1:0] gap_q, gap_d;
    logic [1:0]      frame_q, frame_d;
    logic [7:0]      scan_q, scan_d;
    logic            ready_q, ready_d;
    logic            error_q, error_d;
    logic            clk_q, clk_d;
    logic            data_q, data_d;

    logic [7:0]      lut_scan;
    logic            lut_hit;
    logic            half_end;
    logic [7:0]      tx_byte;
    logic            in_frame;

    ascii_to_scan u_lut (
        .ascii (ascii_in),
        .scan  (lut_scan),
        .hit   (lut_hit)
    );

    assign half_end = (half_q == HC_W'(CLK_DIV - 1));

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        low_d   = low_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        frame_d = frame_q;
        scan_d  = scan_q;
        error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ascii_valid && ready_q) begin
                    if (lut_hit) begin
                        state_d = ST_FRAME;
                        scan_d  = lut_scan;
                        frame_d = 2'd0;
                        bit_d   = 4'd0;
                        gap_d   = '0;
                        half_d  = '0;
                        low_d   = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_FRAME, ST_GAP: begin
                half_d = half_end ? '0 : half_q + HC_W'(1);
                if (half_end)
                    low_d = ~low_q;
                // A bit period ends on the last cycle of its low half.
                if (half_end && low_q) begin
                    if (state_q == ST_FRAME) begin
                        if (bit_q == LAST_BIT) begin
                            state_d = ST_GAP;
                            bit_d   = 4'd0;
                            gap_d   = '0;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else if (gap_q == GC_W'(GAP_BITS - 1)) begin
                        gap_d = '0;
                        if (frame_q == LAST_FRAME) begin
                            state_d = ST_IDLE;
                            frame_d = 2'd0;
                        end else begin
                            state_d = ST_FRAME;
                            frame_d = frame_q + 2'd1;
                        end
                    end else begin
                        gap_d = gap_q + GC_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are derived from the next state so they register in step with it.
        tx_byte  = (frame_d == 2'd1) ? BREAK_CODE : scan_d;
        in_frame = (state_d == ST_FRAME);
        ready_d  = (state_d == ST_IDLE);
        clk_d    = ~(in_frame && low_d);
        data_d   = in_frame ? frame_bit(tx_byte, bit_d) : 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            half_q  <= '0;
            low_q   <= 1'b0;
            bit_q   <= 4'd0;
            gap_q   <= '0;
            frame_q <= 2'd0;
            scan_q  <= 8'h00;
            ready_q <= 1'b1;
            error_q <= 1'b0;
            clk_q   <= 1'b1;
            data_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            low_q   <= low_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            frame_q <= frame_d;
            scan_q  <= scan_d;
            ready_q <= ready_d;
            error_q <= error_d;
            clk_q   <= clk_d;
            data_q  <= data_d;
        end
    end

    assign ready    = ready_q;
    assign error    = error_q;
    assign ps2_clk  = clk_q;
    assign ps2_data = data_q;

endmodule
